// File: rtl/bias_trim_seq.sv
// Wishbone-controlled bias/trim sequencer for the active_load macro: holds the
// enable and manual trim code, and runs a linear trim sweep against the comparator.
module bias_trim_seq #(
  parameter int          TRIM_W   = 6,
  parameter int          SETTLE_W = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              cmp_i,
  output logic              bias_en_o,
  output logic [TRIM_W-1:0] trim_o,
  output logic              irq_o
);

  localparam logic [TRIM_W-1:0] CODE_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  state_t              state_reg, state_next;
  logic                ack_reg;
  logic [31:0]         dat_o_reg;
  logic                en_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic [TRIM_W-1:0]   trim_reg;
  logic                done_reg, found_reg;
  logic [TRIM_W-1:0]   result_reg, code_reg;
  logic [SETTLE_W-1:0] cnt_reg;
  logic                cmp_meta_reg, cmp_s_reg;

  logic                hit, access, wr, rd;
  logic [1:0]          offset;
  logic [31:0]         wmask;
  logic [31:0]         rdata;
  logic                en_next, start_req, w1c_done;
  logic [SETTLE_W-1:0] settle_next, settle_lim;
  logic [TRIM_W-1:0]   trim_next;
  logic                settle_last;
  logic                busy, load_start, step, finish, set_done;
  logic                unused_bits;

  // Bus decode: one access per stb, the cycle holding ack is never a new access.
  assign hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign access = hit && !ack_reg;
  assign wr     = access && wbs_we_i;
  assign rd     = access && !wbs_we_i;
  assign offset = wbs_adr_i[3:2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  assign en_next     = (wr && offset == 2'd0 && wbs_sel_i[0]) ? wbs_dat_i[0] : en_reg;
  assign start_req   = wr && offset == 2'd0 && wbs_sel_i[0] && wbs_dat_i[1] && en_next;
  assign w1c_done    = wr && offset == 2'd3 && wbs_sel_i[0] && wbs_dat_i[1];
  assign settle_next = (settle_reg & ~wmask[SETTLE_W-1:0]) | (wbs_dat_i[SETTLE_W-1:0] & wmask[SETTLE_W-1:0]);
  assign trim_next   = (trim_reg & ~wmask[TRIM_W-1:0]) | (wbs_dat_i[TRIM_W-1:0] & wmask[TRIM_W-1:0]);
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:SETTLE_W], wmask[31:SETTLE_W]};

  // A programmed settle of 0 behaves as 1; >= keeps a shrunk SETTLE from overrunning.
  assign settle_lim  = (settle_reg == '0) ? SETTLE_W'(1) : settle_reg;
  assign settle_last = (cnt_reg >= settle_lim - SETTLE_W'(1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!en_reg && state_reg != ST_IDLE) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   if (start_req) state_next = ST_SETTLE;
        ST_SETTLE: if (settle_last) state_next = ST_SAMPLE;
        ST_SAMPLE: state_next = (cmp_s_reg || code_reg == CODE_MAX) ? ST_DONE : ST_SETTLE;
        ST_DONE:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_reg != ST_IDLE);
    load_start = (state_reg == ST_IDLE) && (state_next == ST_SETTLE);
    step       = (state_reg == ST_SAMPLE) && (state_next == ST_SETTLE);
    finish     = (state_reg == ST_SAMPLE) && (state_next == ST_DONE);
    set_done   = (state_reg == ST_DONE) && en_reg;
    bias_en_o  = en_reg;
    trim_o     = busy ? code_reg : trim_reg;
    irq_o      = done_reg;
    wbs_ack_o  = ack_reg;
    wbs_dat_o  = dat_o_reg;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      2'd0: rdata[0] = en_reg;
      2'd1: rdata[SETTLE_W-1:0] = settle_reg;
      2'd2: rdata[TRIM_W-1:0] = trim_reg;
      default: begin
        rdata[0]           = busy;
        rdata[1]           = done_reg;
        rdata[2]           = found_reg;
        rdata[8 +: TRIM_W] = result_reg;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg      <= 1'b0;
      dat_o_reg    <= '0;
      en_reg       <= 1'b0;
      settle_reg   <= '0;
      trim_reg     <= '0;
      done_reg     <= 1'b0;
      found_reg    <= 1'b0;
      result_reg   <= '0;
      code_reg     <= '0;
      cnt_reg      <= '0;
      cmp_meta_reg <= 1'b0;
      cmp_s_reg    <= 1'b0;
    end else begin
      ack_reg      <= access;
      dat_o_reg    <= rd ? rdata : 32'd0;
      en_reg       <= en_next;
      cmp_meta_reg <= cmp_i;
      cmp_s_reg    <= cmp_meta_reg;
      if (wr && offset == 2'd1) settle_reg <= settle_next;
      if (wr && offset == 2'd2 && !busy) trim_reg <= trim_next;

      if (load_start || step)       cnt_reg <= '0;
      else if (state_reg == ST_SETTLE) cnt_reg <= cnt_reg + SETTLE_W'(1);

      if (load_start) code_reg <= '0;
      else if (step)  code_reg <= code_reg + TRIM_W'(1);

      // On a miss the code is already all-ones, so RESULT=code covers both outcomes.
      if (finish) begin
        found_reg  <= cmp_s_reg;
        result_reg <= code_reg;
      end

      if (set_done)                    done_reg <= 1'b1;
      else if (load_start || w1c_done) done_reg <= 1'b0;
    end
  end

endmodule
